dmem_bridge: RTL and testbench

//  Data-memory bridge directly downstream of the mem stage's request port. Takes one load/store

---
 rtl/dmem_bridge.sv | 126 ++++++++++++
 tb/tb_dmem_bridge.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bridge.sv
// dmem_bridge: turns one mem-stage load/store request into a single req/gnt + rvalid
// bus transaction. Ports: r_v/w_v/req_* in; hit/mem_res/mem_res_error/busy out; bus_* req/resp.
module dmem_bridge #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            r_v,
  input  logic            w_v,
  input  logic [XLEN-1:0] req_adr,
  input  logic [XLEN-1:0] req_data,
  input  logic [3:0]      req_strobe,
  output logic            hit,
  output logic [XLEN-1:0] mem_res,
  output logic            mem_res_error,
  output logic            busy,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_adr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [3:0]      bus_be,
  input  logic            bus_gnt,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata,
  input  logic            bus_err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  logic [XLEN-3:0] wadr_q;
  logic [XLEN-1:0] data_q;
  logic [XLEN-1:0] res_q;
  logic [3:0]      be_q;
  logic            we_q;
  logic            err_q;
  logic [CW-1:0]   cnt;
  logic            be_ok;
  logic            reject;

  always_comb begin
    be_ok = 1'b0;
    unique case (req_strobe)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b0110, 4'b1100, 4'b1111: be_ok = 1'b1;
      default:                            be_ok = 1'b0;
    endcase
  end

  assign reject = (r_v & w_v) | ~be_ok |
                  ((req_strobe == 4'b1111) & (req_adr[1:0] != 2'b00));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      wadr_q <= '0;
      data_q <= '0;
      res_q  <= '0;
      be_q   <= '0;
      we_q   <= 1'b0;
      err_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (r_v | w_v) begin
            wadr_q <= req_adr[XLEN-1:2];
            data_q <= req_data;
            be_q   <= req_strobe;
            we_q   <= w_v;
            res_q  <= '0;
            err_q  <= reject;
            cnt    <= '0;
            state  <= reject ? RESP : REQ;
          end
        end
        REQ: begin
          // abort wins over a grant in the last allowed cycle
          if (cnt == CNT_MAX) begin
            err_q <= 1'b1;
            res_q <= '0;
            state <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
            if (bus_gnt) state <= WAIT;
          end
        end
        WAIT: begin
          // a response in the last allowed cycle still completes
          if (bus_rvalid) begin
            res_q <= (we_q | bus_err) ? '0 : bus_rdata;
            err_q <= bus_err;
            state <= RESP;
          end else if (cnt == CNT_MAX) begin
            err_q <= 1'b1;
            res_q <= '0;
            state <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: state <= IDLE;
      endcase
    end
  end

  assign busy          = (state != IDLE);
  assign bus_req       = (state == REQ);
  assign hit           = (state == RESP);
  assign mem_res       = hit ? res_q : '0;
  assign mem_res_error = hit & err_q;
  assign bus_we        = bus_req & we_q;
  assign bus_adr       = bus_req ? {wadr_q, 2'b00} : '0;
  assign bus_wdata     = bus_req ? data_q : '0;
  assign bus_be        = bus_req ? be_q : '0;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed transactions against a cycle-index model of dmem_bridge;
// each cycle the outputs are compared with what the request/bus timing implies.
module tb_dmem_bridge;

  localparam int T = 16;

  logic        clk;
  logic        rst_n;
  logic        r_v;
  logic        w_v;
  logic [31:0] req_adr;
  logic [31:0] req_data;
  logic [3:0]  req_strobe;
  logic        hit;
  logic [31:0] mem_res;
  logic        mem_res_error;
  logic        busy;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_adr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;

  dmem_bridge #(.XLEN(32), .TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .r_v(r_v), .w_v(w_v),
    .req_adr(req_adr), .req_data(req_data), .req_strobe(req_strobe),
    .hit(hit), .mem_res(mem_res), .mem_res_error(mem_res_error),
    .busy(busy), .bus_req(bus_req), .bus_we(bus_we),
    .bus_adr(bus_adr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int edge_n = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  // model of the open transaction, in cycles counted from the accept edge
  logic        active = 1'b0;
  int          acc_edge = 0;
  int          m_hitk, m_reqk;
  logic        m_w;
  logic [31:0] m_adr, m_data, m_res;
  logic [3:0]  m_be;
  logic        m_err;

  int          seen_hitk, seen_reqn;
  logic [31:0] seen_res;
  logic        seen_err;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  function automatic logic strobe_legal(input logic [3:0] s);
    logic [3:0] legal [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hF};
    foreach (legal[i]) if (legal[i] == s) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin : compare
    int k;
    logic e_busy, e_req, e_hit;
    k      = edge_n - acc_edge + 1;
    e_busy = active && k >= 1 && k <= m_hitk;
    e_req  = active && k >= 1 && k <= m_reqk;
    e_hit  = active && k == m_hitk;
    chk("busy", 32'(busy), 32'(e_busy));
    chk("bus_req", 32'(bus_req), 32'(e_req));
    chk("hit", 32'(hit), 32'(e_hit));
    if (e_hit || !e_busy) begin
      chk("mem_res", mem_res, e_hit ? m_res : 32'h0);
      chk("mem_res_error", 32'(mem_res_error), 32'(e_hit & m_err));
    end
    if (e_req) begin
      chk("bus_we", 32'(bus_we), 32'(m_w));
      chk("bus_adr", bus_adr, {m_adr[31:2], 2'b00});
      chk("bus_wdata", bus_wdata, m_data);
      chk("bus_be", 32'(bus_be), 32'(m_be));
    end
    if (active && bus_req) seen_reqn++;
    if (hit) begin
      seen_hitk = k;
      seen_res  = mem_res;
      seen_err  = mem_res_error;
    end
  end

  // d: stall cycles before gnt; rd: WAIT cycles before rvalid;
  // abort_k: cycle at which rst_n is pulled (0 = never)
  task automatic run_txn(input logic r, input logic w, input logic [31:0] adr,
                         input logic [31:0] data, input logic [3:0] s,
                         input int d, input int rd, input logic [31:0] rdata,
                         input logic berr, input int abort_k);
    logic rej;
    @(posedge clk); #2;
    r_v = r; w_v = w; req_adr = adr; req_data = data; req_strobe = s;
    rej = (r & w) || !strobe_legal(s) || (s == 4'hF && adr[1:0] != 2'b00);
    m_w = w; m_adr = adr; m_data = data; m_be = s;
    if (rej) begin
      m_hitk = 1; m_reqk = 0; m_res = 0; m_err = 1'b1;
    end else if (d + 2 + rd <= T) begin
      m_hitk = d + 3 + rd; m_reqk = d + 1;
      m_err = berr; m_res = (w || berr) ? 32'h0 : rdata;
    end else begin
      m_hitk = T + 1; m_reqk = (d + 1 < T) ? d + 1 : T;
      m_err = 1'b1; m_res = 0;
    end
    seen_hitk = -1; seen_reqn = 0; seen_res = 32'hx; seen_err = 1'bx;
    acc_edge = edge_n + 1;
    active = 1'b1;
    for (int k = 1; k <= m_hitk + 1; k++) begin
      @(posedge clk); #2;
      if (k == abort_k) begin
        rst_n = 1'b0;
        active = 1'b0;
        #1;
        chk("rst busy", 32'(busy), 0);
        chk("rst bus_req", 32'(bus_req), 0);
        chk("rst hit", 32'(hit), 0);
        chk("rst bus_adr", bus_adr, 0);
        chk("rst mem_res", mem_res, 0);
        r_v = 0; w_v = 0; bus_gnt = 0; bus_rvalid = 0;
        bus_rdata = 0; bus_err = 0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        return;
      end
      bus_gnt    = !rej && k == d + 1;
      bus_rvalid = !rej && k == d + 2 + rd;
      bus_rdata  = bus_rvalid ? rdata : 32'h0;
      bus_err    = bus_rvalid ? berr : 1'b0;
      if (k == m_hitk) begin r_v = 0; w_v = 0; end
    end
    active = 1'b0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0; bus_err = 0;
  endtask

  initial begin
    rst_n = 0; r_v = 0; w_v = 0; req_adr = 0; req_data = 0; req_strobe = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0; bus_err = 0;
    seen_hitk = -1; seen_reqn = 0; seen_res = 0; seen_err = 0;
    m_hitk = 0; m_reqk = 0; m_w = 0; m_adr = 0; m_data = 0;
    m_res = 0; m_be = 0; m_err = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    #1;
    chk("reset busy", 32'(busy), 0);
    chk("reset hit", 32'(hit), 0);

    // word load, immediate grant
    run_txn(1, 0, 32'h1000_0004, 0, 4'hF, 0, 0, 32'hDEAD_BEEF, 0, 0);
    chk("load latency", seen_hitk, 3);
    chk("load data", seen_res, 32'hDEAD_BEEF);
    chk("load err", 32'(seen_err), 0);

    // byte store, three stall cycles
    run_txn(0, 1, 32'h0000_2003, 32'hAA00_0000, 4'h8, 3, 0, 32'h5555_5555, 0, 0);
    chk("store req cycles", seen_reqn, 4);
    chk("store res", seen_res, 0);
    chk("store latency", seen_hitk, 6);

    // rejections
    run_txn(1, 0, 32'h0000_1002, 0, 4'hF, 0, 0, 0, 0, 0);
    chk("misalign latency", seen_hitk, 1);
    chk("misalign no bus", seen_reqn, 0);
    chk("misalign err", 32'(seen_err), 1);
    run_txn(1, 1, 32'h0000_1000, 0, 4'hF, 0, 0, 0, 0, 0);
    chk("rw latency", seen_hitk, 1);
    chk("rw err", 32'(seen_err), 1);
    run_txn(1, 0, 32'h0000_1000, 0, 4'h5, 0, 0, 0, 0, 0);
    chk("bad strobe err", 32'(seen_err), 1);
    run_txn(0, 1, 32'h0000_1000, 32'h1, 4'h0, 0, 0, 0, 0, 0);
    chk("zero strobe err", 32'(seen_err), 1);

    // halfword load, grant after one stall, response after one wait
    run_txn(1, 0, 32'h0000_0106, 0, 4'hC, 1, 1, 32'hCAFE_0000, 0, 0);
    chk("half latency", seen_hitk, 5);
    chk("half data", seen_res, 32'hCAFE_0000);

    // timeout with no grant, then a stray response
    run_txn(1, 0, 32'h0000_4000, 0, 4'hF, 1000, 0, 0, 0, 0);
    chk("timeout req cycles", seen_reqn, 16);
    chk("timeout latency", seen_hitk, 17);
    chk("timeout err", 32'(seen_err), 1);
    @(posedge clk); #2;
    bus_rvalid = 1; bus_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #2;
    bus_rvalid = 0; bus_rdata = 0;
    #1 chk("stray hit", 32'(hit), 0);

    // response landing in the last allowed cycle vs one cycle late
    run_txn(1, 0, 32'h0000_4004, 0, 4'hF, 0, 14, 32'h0000_0777, 0, 0);
    chk("edge ok latency", seen_hitk, 17);
    chk("edge ok data", seen_res, 32'h0000_0777);
    run_txn(1, 0, 32'h0000_4008, 0, 4'hF, 0, 15, 32'h0000_0888, 0, 0);
    chk("edge late err", 32'(seen_err), 1);
    chk("edge late res", seen_res, 0);

    // bus error on load and on store
    run_txn(1, 0, 32'h0000_5000, 0, 4'hF, 0, 0, 32'h0000_1234, 1, 0);
    chk("berr res", seen_res, 0);
    chk("berr err", 32'(seen_err), 1);
    run_txn(0, 1, 32'h0000_5004, 32'h0102_0304, 4'hF, 0, 0, 0, 1, 0);
    chk("berr store err", 32'(seen_err), 1);

    // reset while waiting for the response, then a clean load
    run_txn(1, 0, 32'h0000_6000, 0, 4'hF, 0, 5, 32'h1111_1111, 0, 3);
    @(posedge clk); #3;
    chk("between busy", 32'(busy), 0);
    run_txn(1, 0, 32'h3000_0008, 0, 4'hF, 1, 1, 32'h0BAD_F00D, 0, 0);
    chk("post-reset latency", seen_hitk, 5);
    chk("post-reset data", seen_res, 32'h0BAD_F00D);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
